// File: rtl/kuuga_trace_buffer.sv
// Trace record capture FIFO with 32-bit beat serialiser and saturating drop statistics.
// Records are accepted only when a slot is free at the start of the cycle.
module kuuga_trace_buffer #(
    parameter int unsigned TRACE_WIDTH = 96,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned DROP_W      = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     trace_valid,
    input  logic [TRACE_WIDTH-1:0]   trace_data,
    output logic [31:0]              m_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic                     m_last,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [DROP_W-1:0]        drop_count,
    input  logic                     clear_stats
);

    localparam int unsigned WORDS = TRACE_WIDTH / 32;
    localparam int unsigned IW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int unsigned PW    = $clog2(DEPTH);
    localparam int unsigned LW    = PW + 1;

    typedef enum logic {StIdle, StSend} state_e;

    state_e                 state_q, state_d;
    logic [TRACE_WIDTH-1:0] mem [DEPTH];
    logic [TRACE_WIDTH-1:0] head;
    logic [PW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]          level_q, level_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic                   overflow_q;
    logic [DROP_W-1:0]      drop_q;
    logic                   push, full, do_write, drop, hs, last_beat, pop;

    assign push      = enable & trace_valid;
    // Fullness is judged on the start-of-cycle level, so a same-cycle pop never makes room.
    assign full      = (level_q == LW'(DEPTH));
    assign do_write  = push & ~full;
    assign drop      = push & full;
    assign last_beat = (idx_q == IW'(WORDS - 1));
    assign hs        = (state_q == StSend) & m_ready;
    assign pop       = hs & last_beat;
    assign head      = mem[rd_ptr_q];

    assign level      = level_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_q;

    always_comb begin
        level_d = level_q;
        if (do_write && !pop) begin
            level_d = level_q + LW'(1);
        end else if (!do_write && pop) begin
            level_d = level_q - LW'(1);
        end
    end

    always_comb begin
        idx_d = idx_q;
        if (state_q == StIdle) begin
            idx_d = '0;
        end else if (hs) begin
            idx_d = last_beat ? '0 : idx_q + IW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr_q] <= trace_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            idx_q    <= '0;
        end else begin
            if (do_write) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            level_q <= level_d;
            idx_q   <= idx_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else if (drop) begin
            // A drop coinciding with a clear restarts the count at one.
            overflow_q <= 1'b1;
            if (clear_stats) begin
                drop_q <= DROP_W'(1);
            end else if (drop_q != '1) begin
                drop_q <= drop_q + DROP_W'(1);
            end
        end else if (clear_stats) begin
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (level_q != '0) state_d = StSend;
            StSend: if (pop && level_d == '0) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        m_valid = 1'b0;
        m_last  = 1'b0;
        m_data  = '0;
        if (state_q == StSend) begin
            m_valid = 1'b1;
            m_last  = last_beat;
            m_data  = head[int'(idx_q) * 32 +: 32];
        end
    end

endmodule

// File: tb/tb_kuuga_trace_buffer.sv
// Scoreboard bench for kuuga_trace_buffer: stimulus queues expected beats, a negedge
// monitor pops and compares on every handshake.
module tb_kuuga_trace_buffer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, enable, trace_valid, m_ready, clear_stats;
    logic [95:0] trace_data;
    logic [31:0] m_data;
    logic        m_valid, m_last, overflow;
    logic [4:0]  level;
    logic [15:0] drop_count;

    logic        s_enable, s_valid, s_ready, s_clear;
    logic [95:0] s_data;
    logic [31:0] s_m_data;
    logic        s_m_valid, s_m_last, s_overflow;
    logic [1:0]  s_level;
    logic [3:0]  s_drop;

    int          checks = 0;
    int          errors = 0;
    int          beats = 0;
    int          max_level = 0;
    logic [32:0] sb [$];

    kuuga_trace_buffer u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .trace_valid (trace_valid),
        .trace_data  (trace_data),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_last      (m_last),
        .level       (level),
        .overflow    (overflow),
        .drop_count  (drop_count),
        .clear_stats (clear_stats)
    );

    kuuga_trace_buffer #(
        .TRACE_WIDTH (96),
        .DEPTH       (2),
        .DROP_W      (4)
    ) u_sat (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (s_enable),
        .trace_valid (s_valid),
        .trace_data  (s_data),
        .m_data      (s_m_data),
        .m_valid     (s_m_valid),
        .m_ready     (s_ready),
        .m_last      (s_m_last),
        .level       (s_level),
        .overflow    (s_overflow),
        .drop_count  (s_drop),
        .clear_stats (s_clear)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [95:0] rec(input int tag);
        logic [31:0] t;
        t = 32'(tag) << 8;
        return {t | 32'h2, t | 32'h1, t};
    endfunction

    task automatic push_rec(input logic [95:0] d, input bit stored);
        trace_data  = d;
        trace_valid = 1'b1;
        if (stored) begin
            for (int k = 0; k < 3; k++) sb.push_back({k == 2, d[32*k +: 32]});
        end
        @(posedge clk);
        #1;
        trace_valid = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        check(name, 64'(sb.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        logic [32:0] exp;
        if (rst_n && m_valid && m_ready) begin
            beats++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got %0h expected none", m_data);
            end else begin
                exp = sb.pop_front();
                check("beat", 64'({m_last, m_data}), 64'(exp));
            end
        end
        if (int'(level) > max_level) max_level = int'(level);
    end

    initial begin
        int b0;
        rst_n = 1'b0; enable = 1'b0; trace_valid = 1'b0; m_ready = 1'b0; clear_stats = 1'b0;
        trace_data = '0;
        s_enable = 1'b0; s_valid = 1'b0; s_ready = 1'b0; s_clear = 1'b0; s_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_m_last", 64'(m_last), 64'd0);
        check("rst_m_data", 64'(m_data), 64'd0);
        check("rst_level", 64'(level), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_drop", 64'(drop_count), 64'd0);
        rst_n = 1'b1;

        // Single record, one-cycle latency from push to beat 0.
        enable = 1'b1; m_ready = 1'b1;
        push_rec({32'hC, 32'hB, 32'hA}, 1'b1);
        check("lat_level", 64'(level), 64'd1);
        check("lat_valid_low", 64'(m_valid), 64'd0);
        @(posedge clk);
        #1;
        check("lat_valid", 64'(m_valid), 64'd1);
        check("lat_data", 64'(m_data), 64'hA);
        drain("single_drain", 10);
        check("single_valid_end", 64'(m_valid), 64'd0);
        check("single_level_end", 64'(level), 64'd0);

        // Backpressure holds beat 0 stable.
        m_ready = 1'b0;
        push_rec({32'hC, 32'hB, 32'hA}, 1'b1);
        repeat (5) begin
            @(posedge clk);
            #1;
            check("bp_valid", 64'(m_valid), 64'd1);
            check("bp_data", 64'(m_data), 64'hA);
            check("bp_last", 64'(m_last), 64'd0);
        end
        m_ready = 1'b1;
        drain("bp_drain", 10);

        // Overflow: 18 pushes into a 16-deep FIFO.
        m_ready = 1'b0;
        for (int i = 1; i <= 18; i++) push_rec(rec(i), i <= 16);
        check("ovf_level", 64'(level), 64'd16);
        check("ovf_flag", 64'(overflow), 64'd1);
        check("ovf_drop", 64'(drop_count), 64'd2);
        m_ready = 1'b1;
        drain("ovf_drain", 100);
        check("ovf_level_end", 64'(level), 64'd0);
        clear_stats = 1'b1;
        @(posedge clk);
        #1;
        clear_stats = 1'b0;
        check("clr_flag", 64'(overflow), 64'd0);
        check("clr_drop", 64'(drop_count), 64'd0);

        // Streaming at one record per three cycles.
        max_level = 0;
        b0 = beats;
        for (int i = 0; i < 40; i++) begin
            push_rec(rec(i + 100), 1'b1);
            repeat (2) @(posedge clk);
            #1;
        end
        drain("stream_drain", 20);
        check("stream_max_level", 64'(max_level <= 2), 64'd1);
        check("stream_drop", 64'(drop_count), 64'd0);
        check("stream_beats", 64'(beats - b0), 64'd120);

        // Asynchronous reset with beat 2 presented.
        push_rec(rec(7), 1'b1);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(m_valid), 64'd0);
        check("arst_level", 64'(level), 64'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push_rec(rec(9), 1'b1);
        drain("arst_drain", 10);
        check("arst_level_end", 64'(level), 64'd0);

        // Saturating 4-bit drop counter on a 2-deep instance.
        s_enable = 1'b1; s_data = rec(3); s_valid = 1'b1;
        repeat (22) @(posedge clk);
        #1;
        check("sat_drop", 64'(s_drop), 64'hF);
        check("sat_flag", 64'(s_overflow), 64'd1);
        check("sat_level", 64'(s_level), 64'd2);
        repeat (3) @(posedge clk);
        #1;
        check("sat_hold", 64'(s_drop), 64'hF);
        s_valid = 1'b0; s_clear = 1'b1;
        @(posedge clk);
        #1;
        s_clear = 1'b0;
        check("sat_clr", 64'(s_drop), 64'd0);
        s_enable = 1'b0; s_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("dis_drop", 64'(s_drop), 64'd0);
        check("dis_flag", 64'(s_overflow), 64'd0);
        s_enable = 1'b1; s_clear = 1'b1;
        @(posedge clk);
        #1;
        s_valid = 1'b0; s_clear = 1'b0;
        check("clrdrop_drop", 64'(s_drop), 64'd1);
        check("clrdrop_flag", 64'(s_overflow), 64'd1);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/kuuga_trace_buffer.md
Name: kuuga_trace_buffer

Overview:
- Downstream consumer of the processor trace port (`trace_data_o`) of the Kuuga no-cache simulation wrapper.
- Captures each valid trace record into an on-chip FIFO and serialises it into 32-bit beats on a valid/ready stream. The stream feeds a trace sink (bench monitor or DMA).
- Counts records lost when the FIFO is full, so a trace is never silently truncated.

Parameters:
- TRACE_WIDTH, 96: width in bits of one packed trace record; must be a multiple of 32.
- DEPTH, 16: FIFO capacity in whole records; power of two, at least 2.
- DROP_W, 16: width of the drop counter.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  capture enable; records presented while low are ignored, not counted as drops.
- trace_valid  in  1  trace_data holds a new record this cycle.
- trace_data  in  TRACE_WIDTH  packed trace record.
- m_data  out  32  current output beat.
- m_valid  out  1  m_data is valid.
- m_ready  in  1  sink accepts the beat when m_valid and m_ready are both high.
- m_last  out  1  current beat is the final word of its record.
- level  out  $clog2(DEPTH)+1  number of records held, including one partially sent.
- overflow  out  1  sticky: a record was dropped since the last clear.
- drop_count  out  DROP_W  records dropped; saturates at all-ones.
- clear_stats  in  1  synchronous clear of overflow and drop_count.

Behaviour:
- Reset (rst_n low, asynchronous) forces these values:
  - m_valid=0, m_last=0, m_data=0, level=0, overflow=0, drop_count=0.
  - FIFO pointers zero, word index zero, FSM in IDLE.
- WORDS = TRACE_WIDTH/32. Beat k of a record is trace_data[32k+31:32k]; beats go least-significant first, k = 0..WORDS-1.
- Push: on a clk edge with enable=1 and trace_valid=1:
  - If level<DEPTH at the start of the cycle, the record is written and level increments.
  - Otherwise the record is dropped, overflow sets and drop_count increments (saturating).
  - A pop completing in the same cycle does not free space for that push.
- Pop/serialise FSM:
  - IDLE: m_valid=0. When level>0, go to SEND with word index 0.
  - SEND: m_valid=1; m_data is word[index] of the FIFO head; m_last=(index==WORDS-1).
    - On handshake with index<WORDS-1: index increments.
    - On handshake with index==WORDS-1: head pops and level decrements. Then stay in SEND with index 0 if another record remains after the pop, else go to IDLE.
    - With m_ready=0, m_data, m_last and m_valid stay stable; no drop of a presented beat.
- Latency: a record pushed on edge N gives m_valid=1 with beat 0 after edge N+1 when the FIFO was empty. Back-to-back records stream with no idle cycle between m_last of one and beat 0 of the next.
- Simultaneous push and final-beat pop: level is unchanged (+1 −1) when not full.
- Pointers wrap modulo DEPTH; the full/empty distinction comes from level, not pointer equality.
- clear_stats:
  - Zeroes overflow and drop_count on the next edge.
  - A drop in the same cycle wins: the result is overflow=1, drop_count=1.
- enable deasserted mid-stream: records already queued continue to drain.
- The sink must not assume m_valid drops between records.

Test Plan:
- Single record: reset, enable=1, push 96'h0000000C_0000000B_0000000A, m_ready=1.
  - Required: m_data 0xA, 0xB, 0xC on three consecutive cycles starting one cycle after the push.
  - m_last only on 0xC; then m_valid=0 and level=0.
- Backpressure: same record with m_ready=0 for 5 cycles.
  - Required: m_data holds 0xA with m_valid=1 throughout.
  - Releasing m_ready yields 0xA, 0xB, 0xC with no duplication.
- Overflow: m_ready=0, push 18 records with tags 1..18.
  - Required: level=16, overflow=1, drop_count=2.
  - Draining yields records 1..16 in order.
  - Pulse clear_stats: overflow=0, drop_count=0.
- Streaming at rate: m_ready=1, push one record every 3 cycles for 40 records.
  - Required: level never exceeds 2, drop_count=0, 120 beats delivered in order.
  - m_last on every third beat.
- Async reset mid-record: assert rst_n=0 after beat 1 of a record, between clock edges.
  - Required: m_valid=0 and level=0 immediately.
  - After release, the next push emits its own beat 0 first.
- Saturation: with DROP_W=4, force 20 drops.
  - Required: drop_count=4'hF and stays there.
  - enable=0 pushes do not change drop_count.
